// File: rtl/cpu9_pkg.sv
// Shared definitions for the 9-bit pipelined CPU: instruction width,
// well-known encodings and the instruction-memory sequencer states.
package cpu9_pkg;

    localparam int INSTR_W = 9;

    // Bubble instruction inserted on flush and used to pre-fill memory.
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 9'b000000000;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b110111000;

    // Instruction memory lifecycle: sweeping to NOP, then usable until reset.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_clear_seq.sv
// Post-reset clear sequencer for the banked instruction memory.
// Walks every (bank, addr) pair bank-major, one entry per cycle, then
// parks in READY until the next reset.
module imem_clear_seq
    import cpu9_pkg::*;
#(
    parameter int NUM_BANKS      = 4,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 8,
    parameter int BANK_W         = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we,
    output logic [BANK_W-1:0] clr_bank,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam imem_state_t       RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    localparam logic              RST_READY = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    imem_state_t       state_r;
    imem_state_t       next_state_s;
    logic [BANK_W-1:0] bank_r;
    logic [ADDR_W-1:0] addr_r;
    logic              ready_r;
    logic              sweep_last_s;
    logic              clr_we_s;

    // Flags the final entry of the sweep.
    always_comb begin
        sweep_last_s = (bank_r == LAST_BANK) && (addr_r == LAST_ADDR);
    end

    // Next-state and write-enable decode.
    always_comb begin
        next_state_s = state_r;
        clr_we_s     = 1'b0;
        case (state_r)
            CLEAR: begin
                clr_we_s = 1'b1;
                if (sweep_last_s) begin
                    next_state_s = READY;
                end else begin
                    next_state_s = CLEAR;
                end
            end
            READY: begin
                next_state_s = READY;
            end
            default: begin
                next_state_s = RST_STATE;
            end
        endcase
    end

    // State register; ready rises together with the move into READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RST_STATE;
            ready_r <= RST_READY;
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s == READY);
        end
    end

    // Sweep counter: address is the fast index, bank the slow one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r <= {BANK_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (state_r == CLEAR) begin
            if (addr_r == LAST_ADDR) begin
                addr_r <= {ADDR_W{1'b0}};
                if (bank_r == LAST_BANK) begin
                    bank_r <= {BANK_W{1'b0}};
                end else begin
                    bank_r <= bank_r + BANK_W'(1'b1);
                end
            end else begin
                addr_r <= addr_r + ADDR_W'(1'b1);
            end
        end else begin
            bank_r <= bank_r;
            addr_r <= addr_r;
        end
    end

    assign clr_we   = clr_we_s;
    assign clr_bank = bank_r;
    assign clr_addr = addr_r;
    assign ready    = ready_r;

endmodule

// File: rtl/prog_imem_banked.sv
// Multi-bank program memory feeding the IF/ID stage of the 9-bit CPU.
// One-cycle registered fetch with stall/flush, a loader write port and an
// optional NOP-fill sweep after reset.
module prog_imem_banked #(
    parameter int                 INSTR_W        = cpu9_pkg::INSTR_W,
    parameter int                 ADDR_W         = 8,
    parameter int                 DEPTH          = 256,
    parameter int                 NUM_BANKS      = 4,
    parameter int                 BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int                 CLEAR_ON_RESET = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR      = INSTR_W'(cpu9_pkg::NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BANK_W-1:0]  bank_sel,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               rd_en,
    input  logic               stall,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    output logic               ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               oob
);

    // Index width actually needed to address DEPTH entries; upper pc bits
    // only take part in the range check.
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [BANK_W:0]   BANKS_L = (BANK_W + 1)'(NUM_BANKS);

    logic [INSTR_W-1:0] mem_r [NUM_BANKS][DEPTH];

    logic               clr_we_s;
    logic [BANK_W-1:0]  clr_bank_s;
    logic [IDX_W-1:0]   clr_idx_s;
    logic               ready_s;

    logic               rd_oob_s;
    logic [INSTR_W-1:0] rd_data_s;
    logic               wr_ok_s;

    logic [INSTR_W-1:0] instr_r;
    logic               valid_r;
    logic               oob_r;

    imem_clear_seq #(
        .NUM_BANKS      (NUM_BANKS),
        .DEPTH          (DEPTH),
        .ADDR_W         (IDX_W),
        .BANK_W         (BANK_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_we   (clr_we_s),
        .clr_bank (clr_bank_s),
        .clr_addr (clr_idx_s),
        .ready    (ready_s)
    );

    // Fetch range check and read mux; out-of-range fetches return NOP.
    always_comb begin
        rd_oob_s = !(({1'b0, pc} < DEPTH_L) && ({1'b0, bank_sel} < BANKS_L));
        if (rd_oob_s) begin
            rd_data_s = NOP_INSTR;
        end else begin
            rd_data_s = mem_r[bank_sel][pc[IDX_W-1:0]];
        end
    end

    // Load-port range check; out-of-range writes are dropped.
    always_comb begin
        wr_ok_s = ({1'b0, wr_addr} < DEPTH_L) && ({1'b0, wr_bank} < BANKS_L);
    end

    // Storage array, no reset: contents come from the sweep or the loader.
    // The clear sequencer owns the write port while it runs.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_bank_s][clr_idx_s] <= NOP_INSTR;
        end else if (ready_s && wr_en && wr_ok_s) begin
            mem_r[wr_bank][wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Fetch output register: flush beats stall beats a new fetch.
    // Reading and writing share the edge, so a same-entry write is seen
    // by the following fetch (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
            oob_r   <= 1'b0;
        end else if (!ready_s) begin
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
            oob_r   <= 1'b0;
        end else if (flush) begin
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
            oob_r   <= 1'b0;
        end else if (stall) begin
            instr_r <= instr_r;
            valid_r <= valid_r;
            oob_r   <= oob_r;
        end else if (rd_en) begin
            instr_r <= rd_data_s;
            valid_r <= 1'b1;
            oob_r   <= rd_oob_s;
        end else begin
            instr_r <= instr_r;
            valid_r <= 1'b0;
            oob_r   <= oob_r;
        end
    end

    assign ready       = ready_s;
    assign instr_out   = instr_r;
    assign instr_valid = valid_r;
    assign oob         = oob_r;

endmodule

// File: tb/tb_prog_imem_banked.sv
// Scoreboard bench for prog_imem_banked (DEPTH=8, NUM_BANKS=2, clear on reset).
module tb_prog_imem_banked;
    import cpu9_pkg::*;

    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 8;
    localparam int NUM_BANKS = 2;
    localparam int BANK_W    = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [BANK_W-1:0] bank_sel;
    logic [ADDR_W-1:0] pc;
    logic              rd_en, stall, flush, wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        wr_data;
    logic              ready;
    logic [8:0]        instr_out;
    logic              instr_valid;
    logic              oob;

    typedef struct {
        int         cyc;
        logic [8:0] instr;
        logic       valid;
        logic       oob;
        string      name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    prog_imem_banked #(
        .INSTR_W        (9),
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .NUM_BANKS      (NUM_BANKS),
        .BANK_W         (BANK_W),
        .CLEAR_ON_RESET (1),
        .NOP_INSTR      (9'b000000000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bank_sel    (bank_sel),
        .pc          (pc),
        .rd_en       (rd_en),
        .stall       (stall),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ready       (ready),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .oob         (oob)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops the expectation due this cycle and compares it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                tests++;
                fails++;
                $display("FAIL %s: response due at cycle %0d was never observed", e.name, e.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                tests++;
                if (instr_out !== e.instr || instr_valid !== e.valid || oob !== e.oob) begin
                    fails++;
                    $display("FAIL %s: got instr=%b valid=%b oob=%b, want instr=%b valid=%b oob=%b",
                             e.name, instr_out, instr_valid, oob, e.instr, e.valid, e.oob);
                end
            end else if (rst_n === 1'b1 && instr_valid === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid=%b instr=%b at cycle %0d, want no valid output",
                         instr_valid, instr_out, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [8:0] instr, input logic v, input logic o);
        exp_t e;
        e.cyc   = cyc + 1;
        e.instr = instr;
        e.valid = v;
        e.oob   = o;
        e.name  = name;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic fetch(input string name, input int b, input int a, input logic [8:0] instr, input logic o);
        rd_en    = 1'b1;
        bank_sel = BANK_W'(b);
        pc       = ADDR_W'(a);
        expect_out(name, instr, 1'b1, o);
        tick();
    endtask

    // Counts clock edges from now until ready is seen high.
    task automatic wait_ready(input string name, input int want);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready === 1'b1) begin
                n = i;
                break;
            end
        end
        check(name, n, want);
    endtask

    initial begin
        rst_n = 1'b0;
        bank_sel = '0; pc = '0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        idle();

        // Reset state
        #12;
        check("rst_ready", ready, 0);
        check("rst_instr", instr_out, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_oob", oob, 0);

        // 1: sweep of 16 entries, then every entry reads NOP
        rst_n = 1'b1;
        wait_ready("sweep_len", 16);
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                fetch($sformatf("clear_b%0d_a%0d", b, a), b, a, 9'b000000000, 1'b0);
            end
        end
        idle();
        expect_out("idle_after_sweep", 9'b000000000, 1'b0, 1'b0);
        tick();

        // 2: bank-separated writes and fetches
        wr_en = 1'b1; wr_bank = 1'b1; wr_addr = 8'd3; wr_data = 9'b100100001;
        tick();
        wr_bank = 1'b0; wr_data = 9'b011000000;
        tick();
        wr_en = 1'b0;
        fetch("bank1_a3", 1, 3, 9'b100100001, 1'b0);
        fetch("bank0_a3", 0, 3, 9'b011000000, 1'b0);
        idle();
        expect_out("idle_after_fetch", 9'b011000000, 1'b0, 1'b0);
        tick();

        // 3: stall holds while pc moves; flush beats stall
        fetch("stall_fetch", 1, 3, 9'b100100001, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = ADDR_W'(4 + i);
            expect_out($sformatf("stall_hold%0d", i), 9'b100100001, 1'b1, 1'b0);
            tick();
        end
        flush = 1'b1;
        expect_out("flush_over_stall", 9'b000000000, 1'b0, 1'b0);
        tick();
        idle();
        expect_out("idle_after_flush", 9'b000000000, 1'b0, 1'b0);
        tick();

        // 4: same-cycle read and write returns old data first
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 8'd5; wr_data = HALT_INSTR;
        fetch("rw_same_old", 0, 5, 9'b000000000, 1'b0);
        wr_en = 1'b0;
        fetch("rw_same_new", 0, 5, 9'b110111000, 1'b0);
        idle();
        tick();

        // 5: out-of-range fetch and dropped out-of-range write
        fetch("oob_fetch", 0, 9, 9'b000000000, 1'b1);
        idle();
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 8'd9; wr_data = 9'b111111111;
        tick();
        wr_en = 1'b0;
        fetch("oob_write_no_alias", 0, 1, 9'b000000000, 1'b0);
        fetch("oob_fetch_b1", 1, 9, 9'b000000000, 1'b1);
        flush = 1'b1; rd_en = 1'b1; pc = 8'd3;
        expect_out("flush_clears_oob", 9'b000000000, 1'b0, 1'b0);
        tick();
        idle();
        tick();

        // 6: async reset from READY, then reset mid-sweep restarts it
        fetch("pre_reset_fetch", 1, 3, 9'b100100001, 1'b0);
        idle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_instr", instr_out, 0);
        check("async_rst_valid", instr_valid, 0);
        check("async_rst_ready", ready, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check("mid_sweep_ready", ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_sweep_rst_ready", ready, 0);
        #1;
        rst_n = 1'b1;
        wait_ready("sweep_restart_len", 16);
        fetch("cleared_b1_a3", 1, 3, 9'b000000000, 1'b0);
        fetch("cleared_b0_a5", 0, 5, 9'b000000000, 1'b0);
        idle();
        tick();
        tick();
        tick();

        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
